// File: rtl/instruction_buffer_if.sv
// Fetch/dispatch-facing signal bundle of the instruction buffer.
// slave = the buffer itself, master = the fetch/dispatch side driving it.
interface instruction_buffer_if #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 38
);
  logic                     in_valid;
  logic [4*ENTRY_W-1:0]     in_entries_flat;
  logic                     is_jump;
  logic [2:0]               num_fetch;
  logic [4*ENTRY_W-1:0]     out_entries_flat;
  logic [3:0]               out_valid;
  logic [2:0]               deq_cnt;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_entries_flat, is_jump, deq_cnt,
    input  num_fetch, out_entries_flat, out_valid, count
  );

  modport slave (
    input  in_valid, in_entries_flat, is_jump, deq_cnt,
    output num_fetch, out_entries_flat, out_valid, count
  );
endinterface

// File: rtl/instruction_buffer.sv
// Program-order circular queue between fetch/decode and rename/dispatch: up to 4 in, 4 oldest out, flush on jump.
// Optional IBUF_PERF_EN adds saturating full-cycle and flush counters.
module instruction_buffer #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 38
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_buffer_if.slave   ib
`ifdef IBUF_PERF_EN
  ,
  output logic [15:0]           perf_full_cycles,
  output logic [7:0]            perf_flushes
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q;

  logic [CW-1:0]      free_d;
  logic [2:0]         num_fetch_d;
  logic [2:0]         enq_n;
  logic [2:0]         deq_n;

  // Credit to fetch looks only at registered occupancy, so same-cycle dequeue is never counted on.
  always_comb begin
    free_d      = CW'(DEPTH) - count_q;
    num_fetch_d = (free_d >= CW'(4)) ? 3'd4 : free_d[2:0];
    enq_n       = ib.in_valid ? num_fetch_d : 3'd0;
    deq_n       = (CW'(ib.deq_cnt) > count_q) ? count_q[2:0] : ib.deq_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (ib.is_jump) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < enq_n) begin
          mem_q[tail_q + AW'(i)] <= ib.in_entries_flat[ENTRY_W*(3-i) +: ENTRY_W];
        end
      end
      head_q  <= head_q + AW'(deq_n);
      tail_q  <= tail_q + AW'(enq_n);
      count_q <= count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  always_comb begin
    ib.num_fetch        = num_fetch_d;
    ib.count            = count_q;
    ib.out_entries_flat = '0;
    ib.out_valid        = '0;
    for (int i = 0; i < 4; i++) begin
      ib.out_entries_flat[ENTRY_W*(3-i) +: ENTRY_W] = mem_q[head_q + AW'(i)];
      ib.out_valid[i] = (CW'(i) < count_q);
    end
  end

`ifdef IBUF_PERF_EN
  logic [15:0] full_cycles_q;
  logic [7:0]  flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cycles_q <= '0;
      flushes_q     <= '0;
    end else begin
      if (count_q == CW'(DEPTH) && full_cycles_q != 16'hFFFF) begin
        full_cycles_q <= full_cycles_q + 16'd1;
      end
      if (ib.is_jump && flushes_q != 8'hFF) begin
        flushes_q <= flushes_q + 8'd1;
      end
    end
  end

  assign perf_full_cycles = full_cycles_q;
  assign perf_flushes     = flushes_q;
`endif

endmodule

// File: tb/tb_instruction_buffer.sv
// Randomized + directed bench for instruction_buffer against a queue-based program-order model.
module tb_instruction_buffer;
  localparam int DEPTH = 8;
  localparam int EW    = 38;
  typedef logic [EW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_buffer_if #(.DEPTH(DEPTH), .ENTRY_W(EW)) ibif ();

`ifdef IBUF_PERF_EN
  logic [15:0] pfc;
  logic [7:0]  pfl;
`endif

  instruction_buffer #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ib    (ibif)
`ifdef IBUF_PERF_EN
    ,
    .perf_full_cycles (pfc),
    .perf_flushes     (pfl)
`endif
  );

  int errors = 0;
  int checks = 0;
  ent_t mq[$];
  int   m_full = 0;
  int   m_flush = 0;
  ent_t A[4], B[4], C[4], D[4], E[4], F[4], Z[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t rnd_ent();
    return ent_t'({$urandom, $urandom});
  endfunction

  function automatic int model_nf();
    return (DEPTH - mq.size() < 4) ? DEPTH - mq.size() : 4;
  endfunction

  function automatic ent_t slot(input int i);
    return ibif.out_entries_flat[EW*(3-i) +: EW];
  endfunction

  task automatic check_all();
    logic [3:0] ov;
    ov = '0;
    for (int i = 0; i < 4; i++) ov[i] = (i < mq.size());
    chk("count", 64'(ibif.count), 64'(mq.size()));
    chk("num_fetch", 64'(ibif.num_fetch), 64'(model_nf()));
    chk("out_valid", 64'(ibif.out_valid), 64'(ov));
    for (int i = 0; i < 4 && i < mq.size(); i++) chk($sformatf("slot%0d", i), 64'(slot(i)), 64'(mq[i]));
`ifdef IBUF_PERF_EN
    chk("perf_full_cycles", 64'(pfc), 64'(m_full));
    chk("perf_flushes", 64'(pfl), 64'(m_flush));
`endif
  endtask

  // Called just after a falling edge: applies inputs, advances the model, checks after the next edge.
  task automatic step(input bit iv, input ent_t e[4], input bit jmp, input int dq);
    int nf, dn;
    ibif.in_valid = iv;
    ibif.is_jump  = jmp;
    ibif.deq_cnt  = 3'(dq);
    for (int i = 0; i < 4; i++) ibif.in_entries_flat[EW*(3-i) +: EW] = e[i];
    checks++;
    if (dq > int'(ibif.count)) begin
      errors++;
      $display("FAIL deq_clamp: deq_cnt %0d exceeds count %0d", dq, ibif.count);
    end
    if (mq.size() == DEPTH && m_full < 65535) m_full++;
    if (jmp) begin
      if (m_flush < 255) m_flush++;
      mq.delete();
    end else begin
      nf = model_nf();
      dn = (dq < mq.size()) ? dq : mq.size();
      repeat (dn) void'(mq.pop_front());
      if (iv) for (int i = 0; i < nf; i++) mq.push_back(e[i]);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    ibif.in_valid = 1'b0;
    ibif.is_jump  = 1'b0;
    ibif.deq_cnt  = 3'd0;
    ibif.in_entries_flat = '0;
    for (int i = 0; i < 4; i++) begin
      A[i] = rnd_ent(); B[i] = rnd_ent(); C[i] = rnd_ent();
      D[i] = rnd_ent(); E[i] = rnd_ent(); F[i] = rnd_ent(); Z[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk("rst_count", 64'(ibif.count), 64'd0);
    chk("rst_out_valid", 64'(ibif.out_valid), 64'd0);
    chk("rst_num_fetch", 64'(ibif.num_fetch), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_slot%0d", i), 64'(slot(i)), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    step(1, A, 0, 0);
    chk("fill_count", 64'(ibif.count), 64'd4);
    chk("fill_valid", 64'(ibif.out_valid), 64'hF);
    chk("fill_slot0", 64'(slot(0)), 64'(A[0]));
    step(1, B, 0, 0);
    chk("full_count", 64'(ibif.count), 64'd8);
    chk("full_nf", 64'(ibif.num_fetch), 64'd0);
    step(1, C, 0, 0);
    chk("full_ignore", 64'(ibif.count), 64'd8);
    step(0, Z, 0, 2);
    step(1, D, 0, 0);
    chk("partial_count", 64'(ibif.count), 64'd8);
    step(0, Z, 0, 3);
    chk("deq3_count", 64'(ibif.count), 64'd5);
    chk("deq3_slot0", 64'(slot(0)), 64'(B[1]));
    step(1, F, 1, 2);
    chk("flush_count", 64'(ibif.count), 64'd0);
    chk("flush_valid", 64'(ibif.out_valid), 64'd0);
    chk("flush_nf", 64'(ibif.num_fetch), 64'd4);

    // Walk head and tail to index 6 with an empty queue so the next bundle straddles 7->0.
    step(1, A, 0, 0); step(1, B, 0, 0); step(0, Z, 0, 2); step(1, C, 0, 0);
    step(0, Z, 0, 4); step(1, D, 0, 0); step(0, Z, 0, 4); step(0, Z, 0, 4);
    step(1, E, 0, 0);
    chk("wrap_count", 64'(ibif.count), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_slot%0d", i), 64'(slot(i)), 64'(E[i]));

    step(1, F, 0, 0);
    step(0, Z, 0, 1);
    chk("pre_rst_count", 64'(ibif.count), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(ibif.count), 64'd0);
    chk("arst_valid", 64'(ibif.out_valid), 64'd0);
`ifdef IBUF_PERF_EN
    chk("arst_perf_full", 64'(pfc), 64'd0);
    chk("arst_perf_flush", 64'(pfl), 64'd0);
`endif
    mq.delete();
    m_full = 0;
    m_flush = 0;
    ibif.in_valid = 1'b0;
    ibif.is_jump  = 1'b0;
    ibif.deq_cnt  = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    for (int n = 0; n < 1500; n++) begin
      ent_t r[4];
      int   dq;
      for (int i = 0; i < 4; i++) r[i] = rnd_ent();
      dq = $urandom_range(0, 4);
      if (dq > mq.size()) dq = mq.size();
      step(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 24) == 0), dq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_buffer.md
# instruction_buffer

Decoupling queue between the fetch/decode stage and rename/dispatch. It accepts up to four decoded instruction entries per cycle from fetch, holds them in program order in a circular buffer, and presents up to four oldest entries to dispatch. It advertises its free space back to fetch as `num_fetch`, and it is flushed on a taken jump.

## Interface
Parameters:
- `DEPTH`, 8 — entry count; power of two, ≥4.
- `ENTRY_W`, 38 — entry width. Field order from MSB: opcode[4], imm[8], rt[4], ra[4], rb[4], a_dep[1], a_owner[4], b_dep[1], b_owner[4], uses_rb[1], is_ld_str[1], is_fxu[1], is_branch[1].

Ports:
- `clk`  in  1  — rising-edge clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — fetch bundle valid (fetch `if_valid_out`).
- `in_entries_flat`  in  4*ENTRY_W  — slot 0 (oldest) at the MSB end; slot i at [ENTRY_W*(4-i)-1 : ENTRY_W*(3-i)].
- `is_jump`  in  1  — flush request from the branch unit.
- `num_fetch`  out  3  — entries fetch may deliver this cycle, = min(4, DEPTH-count).
- `out_entries_flat`  out  4*ENTRY_W  — oldest four entries, same slot ordering as input.
- `out_valid`  out  4  — bit i set when out slot i holds a live entry; thermometer-coded from bit 0.
- `deq_cnt`  in  3  — entries dispatch consumes this cycle (0–4).
- `count`  out  $clog2(DEPTH)+1  — current occupancy.

## Operation
- Storage: DEPTH×ENTRY_W register array. Pointers: `head` (oldest) and `tail` (next write), each $clog2(DEPTH) bits, wrapping modulo DEPTH. `count` is a register, 0..DEPTH.
- Enqueue amount: `enq_n = in_valid ? num_fetch : 0`.
  - Input slots 0..enq_n-1 are written to tail, tail+1, ….
  - The remaining slots are dropped. Fetch re-supplies them from its held PC.
- Dequeue amount: `deq_n = min(deq_cnt, count)`. A `deq_cnt` larger than `count` is clamped; a bench assertion flags it.
- Next state: `head += deq_n`, `tail += enq_n`, `count += enq_n - deq_n`.
- `num_fetch` is derived from the registered `count` only. It ignores same-cycle dequeue, which is conservative, so overflow is impossible.
- Outputs: `out_valid[i] = (i < count)`. Out slot i is `mem[head+i mod DEPTH]`.
  - Slots with `out_valid[i]=0` carry stale data; dispatch ignores them.
- Flush: when `is_jump=1`, at the next edge `head=tail=count=0`. Same-cycle enqueue and dequeue are discarded, and flush wins over both. Storage contents are not cleared.
- No FSM. Status is carried by the pointers and `count`.

## Timing
- Reset (async assert, sync-safe release): `head=tail=count=0`, `out_valid=0`, `out_entries_flat=0`, `num_fetch=min(4,DEPTH)`.
- Enqueue→visible latency: an entry written at edge N appears on `out_*` after edge N. There is no same-cycle bypass.
- Dequeue takes effect at the clock edge. The next entries shift into slot 0 in the following cycle.
- Full (`count=DEPTH`): `num_fetch=0`, and `in_valid` is ignored.
- Empty (`count=0`): `out_valid=0`, and `deq_cnt` is ignored.
- Wrap-around: reads and writes that straddle index DEPTH-1→0 are contiguous in program order.
- Simultaneous full enqueue and dequeue while at `count=DEPTH-4`: 4 entries are accepted, up to 4 are removed, and count stays ≤DEPTH.
- Reset asserted mid-operation: all state clears immediately, regardless of `clk`.

## Configuration
- `IBUF_PERF_EN` defined: adds output `perf_full_cycles` (16-bit, saturating) and output `perf_flushes` (8-bit, saturating).
  - `perf_full_cycles` increments every cycle with `count=DEPTH`.
  - `perf_flushes` increments on each `is_jump` cycle.
  - Both counters reset to 0.
- `IBUF_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then idle → `count=0`, `out_valid=4'b0000`, `num_fetch=4`.
- Fill: `in_valid=1` with entries A0–A3, `deq_cnt=0` → next cycle `count=4`, `out_valid=4'b1111`, slot0=A0. Deliver B0–B3 → `count=8`, `num_fetch=0`. A further bundle C is ignored and `count` stays 8.
- Partial space: `count=6`, `deq_cnt=0`, bundle D0–D3 → only D0,D1 are accepted, `count=8`. Then `deq_cnt=3` → `count=5`, slot0 = the 4th-oldest entry.
- Wrap-around: after 3 enqueue/dequeue rounds leave `head=6`, enqueue 4 entries E0–E3 → they occupy indices 6,7,0,1, and out slots 0..3 = E0..E3 in order.
- Flush: `count=5`, `is_jump=1` with `in_valid=1` and `deq_cnt=2` → next cycle `count=0`, `out_valid=0`, `num_fetch=4`.
- Async reset mid-fill: assert `rst_n=0` between clock edges at `count=7` → `count=0` immediately; with `IBUF_PERF_EN` defined, both perf counters read 0.
